// File: rtl/mem_arb_pkg.sv
// Shared types for the memory bus arbiter.
// Optional round-robin build: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

    localparam int BE_W = 4;
    localparam logic [BE_W-1:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: LS wins a collision unless it won the last one.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
    input  logic last,
    input  logic idle,
    output logic if_gnt,
    output logic ls_gnt
);

    logic ls_first;

    always_comb begin
        ls_first = (last == REQ_IF);
        ls_gnt   = idle & ls_req & (~if_req | ls_first);
        if_gnt   = idle & if_req & (~ls_req | ~ls_first);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority on collisions.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_re,
    input  logic [BE_W-1:0]   ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_re,
    output logic [BE_W-1:0]   bus_we,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

    state_t            state_q, state_d;
    req_id_t           who_q, who_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   we_q, we_d;
    logic              re_q, re_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic last_win;
    logic ls_null;
    logic timeout;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (ls_gnt) begin
            last_d = REQ_LS;
        end else if (if_gnt) begin
            last_d = REQ_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= REQ_IF;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_win = last_q;
`else
    assign last_win = REQ_IF;
`endif

    mem_arb_pick u_pick (
        .if_req (if_req),
        .ls_req (ls_req),
        .last   (last_win),
        .idle   ((state_q == IDLE) & ~rst),
        .if_gnt (if_gnt),
        .ls_gnt (ls_gnt)
    );

    assign ls_null = ~ls_re & (ls_we == WE_NONE);
    assign timeout = (MAX_WAIT > 0) && (wait_q == WAIT_LIM - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            who_q      <= REQ_IF;
            addr_q     <= '0;
            we_q       <= WE_NONE;
            re_q       <= 1'b0;
            wdata_q    <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            who_q      <= who_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            re_q       <= re_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ls_gnt) begin
                    state_d = ls_null ? RESP : BUSY;
                end else if (if_gnt) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus_ready || timeout) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches, wait counter and read-data capture.
    always_comb begin
        who_d      = who_q;
        addr_d     = addr_q;
        we_d       = we_q;
        re_d       = re_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if (ls_gnt) begin
            who_d   = REQ_LS;
            addr_d  = ls_addr;
            we_d    = ls_we;
            re_d    = ls_re & (ls_we == WE_NONE);
            wdata_d = ls_wdata;
            wait_d  = '0;
            err_d   = 1'b0;
            if (ls_null) begin
                ls_rdata_d = '0;
            end
        end else if (if_gnt) begin
            who_d   = REQ_IF;
            addr_d  = if_addr;
            we_d    = WE_NONE;
            re_d    = 1'b1;
            wdata_d = '0;
            wait_d  = '0;
            err_d   = 1'b0;
        end
        if (state_q == BUSY) begin
            if (bus_ready) begin
                if (re_q && who_q == REQ_LS) begin
                    ls_rdata_d = bus_rdata;
                end else if (re_q) begin
                    if_rdata_d = bus_rdata;
                end
            end else if (timeout) begin
                err_d = 1'b1;
                if (who_q == REQ_LS) begin
                    ls_rdata_d = '0;
                end else begin
                    if_rdata_d = '0;
                end
            end else begin
                wait_d = wait_q + CW'(1);
            end
        end
    end

    always_comb begin
        bus_re    = 1'b0;
        bus_we    = WE_NONE;
        bus_addr  = '0;
        bus_wdata = '0;
        if (state_q == BUSY) begin
            bus_re    = re_q;
            bus_we    = we_q;
            bus_addr  = addr_q;
            bus_wdata = wdata_q;
        end
        if_done = (state_q == RESP) && (who_q == REQ_IF);
        ls_done = (state_q == RESP) && (who_q == REQ_LS);
        ls_err  = ls_done & err_q;
    end

    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_done;
    logic [31:0] if_rdata;
    logic        ls_req, ls_re;
    logic [3:0]  ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_done, ls_err;
    logic [31:0] ls_rdata;
    logic [31:0] bus_addr;
    logic        bus_re;
    logic [3:0]  bus_we;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ready;

    int n_checks = 0;
    int n_errs   = 0;

    bit          last_ls;
    logic [31:0] m_if_rd, m_ls_rd;
    bit          t_ls, t_re;
    logic [3:0]  t_we;
    logic [31:0] t_addr, t_wdata;

    mem_bus_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_re     (ls_re),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .bus_addr  (bus_addr),
        .bus_re    (bus_re),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick_ls(input bit if_r, input bit ls_r);
        if (!if_r) return 1'b1;
        if (!ls_r) return 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return !last_ls;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int rand_k();
        return ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 4));
    endfunction

    task automatic rand_ls();
        int r;
        r = int'($urandom_range(0, 3));
        ls_req   = 1'b1;
        ls_addr  = $urandom;
        ls_wdata = $urandom;
        case (r)
            0: begin ls_re = 1'b0; ls_we = 4'b0; end
            1: begin ls_re = 1'b1; ls_we = 4'b0; end
            2: begin ls_re = 1'b0; ls_we = 4'($urandom_range(1, 15)); end
            default: begin ls_re = 1'b1; ls_we = 4'($urandom_range(1, 15)); end
        endcase
    endtask

    // Record the access the winner presents, check the grant, advance.
    task automatic take(input bit ls);
        t_ls    = ls;
        t_re    = ls ? (ls_re && ls_we == 4'b0) : 1'b1;
        t_we    = ls ? ls_we : 4'b0;
        t_addr  = ls ? ls_addr : if_addr;
        t_wdata = ls ? ls_wdata : 32'h0;
        #1;
        chk("gnt", {if_gnt, ls_gnt}, ls ? 2'b01 : 2'b10);
        last_ls = ls;
        tick();
    endtask

    // Run the granted access to completion; ready comes in busy cycle k.
    task automatic finish(input int k, input bit poke, input logic [31:0] rdv);
        int n = 0;
        bit seen = 0;
        int exp_n;
        bit nul, tmo;
        logic [31:0] rd = '0;
        nul   = t_ls && !t_re && t_we == 4'b0;
        tmo   = !nul && (k < 1 || k > MAXW);
        exp_n = nul ? 0 : (tmo ? MAXW : k);
        if (t_ls) begin
            ls_req = 1'b0; ls_re = 1'($urandom); ls_we = 4'($urandom);
            ls_addr = $urandom; ls_wdata = $urandom;
        end else begin
            if_req = 1'b0; if_addr = $urandom;
        end
        while (!seen && n < 40) begin
            if (if_done || ls_done) begin
                seen = 1;
            end else begin
                n++;
                bus_ready = (n == k);
                bus_rdata = (n == k) ? rdv : $urandom;
                if (n == k) rd = rdv;
                if (poke && t_ls) begin
                    if_req = 1'b1; if_addr = $urandom;
                end else if (poke) begin
                    ls_req = 1'b1; ls_re = 1'b1; ls_we = 4'b0;
                    ls_addr = $urandom;
                end
                #1;
                chk("busy_gnt", {if_gnt, ls_gnt}, 2'b00);
                chk("busy_bus", {bus_re, bus_we, bus_addr}, {t_re, t_we, t_addr});
                if (t_we != 4'b0) chk("busy_wdata", bus_wdata, t_wdata);
                tick();
            end
        end
        bus_ready = 1'($urandom);
        chk("done_seen", seen, 1'b1);
        if (seen) begin
            chk("busy_cycles", n, exp_n);
            chk("done_port", {if_done, ls_done}, t_ls ? 2'b01 : 2'b10);
            if (t_ls) begin
                if (nul || tmo) m_ls_rd = '0;
                else if (t_re) m_ls_rd = rd;
                chk("ls_err", ls_err, tmo);
                chk("ls_rdata", ls_rdata, m_ls_rd);
                chk("if_rdata_hold", if_rdata, m_if_rd);
            end else begin
                m_if_rd = tmo ? 32'h0 : rd;
                chk("if_rdata", if_rdata, m_if_rd);
                chk("ls_err_if", ls_err, 1'b0);
                chk("ls_rdata_hold", ls_rdata, m_ls_rd);
            end
            chk("resp_gnt", {if_gnt, ls_gnt}, 2'b00);
            chk("resp_bus", {bus_re, bus_we}, 5'b0);
        end
        if (poke && t_ls) if_req = 1'b0;
        else if (poke) ls_req = 1'b0;
        tick();
        chk("pulse", {if_done, ls_done}, 2'b00);
        chk("idle_bus", {bus_re, bus_we}, 5'b0);
    endtask

    task automatic collide(input int k1, input int k2);
        bit w;
        if_req = 1'b1; if_addr = $urandom;
        rand_ls();
        w = pick_ls(1'b1, 1'b1);
        take(w);
        finish(k1, 1'b0, $urandom);
        take(!w);
        finish(k2, 1'b0, $urandom);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = 0;
        ls_req = 0; ls_re = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
        bus_rdata = 0; bus_ready = 0;
        last_ls = 0; m_if_rd = 0; m_ls_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        if_req = 1'b1; ls_req = 1'b1;
        #1;
        chk("rst_ctl", {if_gnt, ls_gnt, if_done, ls_done, ls_err, bus_re, bus_we}, 10'b0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_rdata", {if_rdata, ls_rdata}, 64'h0);
        if_req = 1'b0; ls_req = 1'b0;
        tick();
        rst = 1'b0;

        if_req = 1'b1; if_addr = 32'h100;
        take(1'b0);
        finish(1, 1'b0, 32'hDEADBEEF);
        chk("if_read_val", if_rdata, 32'hDEADBEEF);

        ls_req = 1'b1; ls_re = 1'b0; ls_we = 4'b0100;
        ls_addr = 32'h203; ls_wdata = 32'h00AB0000;
        take(1'b1);
        finish(3, 1'b1, $urandom);

        repeat (3) collide(1, 1);

        ls_req = 1'b1; ls_re = 1'b0; ls_we = 4'b0;
        ls_addr = $urandom; ls_wdata = $urandom;
        take(1'b1);
        finish(1, 1'b0, $urandom);

        ls_req = 1'b1; ls_re = 1'b1; ls_we = 4'b0; ls_addr = 32'h40;
        take(1'b1);
        finish(0, 1'b0, $urandom);
        if_req = 1'b1; if_addr = 32'h44;
        take(1'b0);
        finish(2, 1'b0, $urandom);

        // Reset in the second busy cycle abandons the store.
        bus_ready = 1'b0;
        ls_req = 1'b1; ls_re = 1'b0; ls_we = 4'b1111;
        ls_addr = 32'h80; ls_wdata = $urandom;
        take(1'b1);
        ls_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_bus", {bus_re, bus_we}, 5'b0);
        last_ls = 0; m_if_rd = 0; m_ls_rd = 0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_no_done", {if_done, ls_done}, 2'b00);
            tick();
        end
        chk("rst_rdata_clr", {if_rdata, ls_rdata}, 64'h0);
        if_req = 1'b1; if_addr = $urandom;
        take(1'b0);
        finish(1, 1'b0, $urandom);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                collide(rand_k(), rand_k());
            end else if ($urandom_range(0, 1) == 0) begin
                rand_ls();
                take(1'b1);
                finish(rand_k(), 1'($urandom), $urandom);
            end else begin
                if_req = 1'b1; if_addr = $urandom;
                take(1'b0);
                finish(rand_k(), 1'($urandom), $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
